// File: rtl/store_exec_ctrl_pkg.sv
// store_exec_ctrl_pkg: shared constants, FSM/error encodings and immediate sign-extension helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: XLEN, RISC-V store opcode/funct3 codes, state_t, err_t, sext12().
package store_exec_ctrl_pkg;

   // Address/data width; the datapath is written for 32 bits only.
   localparam int XLEN = 32;

   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [2:0] F3_SB     = 3'b000;
   localparam logic [2:0] F3_SH     = 3'b001;
   localparam logic [2:0] F3_SW     = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_READ   = 3'd2,
      S_EXEC   = 3'd3,
      S_REQ    = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   // Cause carried into the one-cycle ERR state so the right pulse fires.
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ILLEGAL  = 2'd1,
      ERR_MISALIGN = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_t;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
      return {{(XLEN-12){imm[11]}}, imm};
   endfunction

endpackage

// File: rtl/store_exec_ctrl_if.sv
// store_exec_ctrl_if: register-file read port and data-memory write port of the store sequencer.
// Latency: n/a (wires only); rf_rdata* valid the cycle after rf_rd_en.
// Backpressure: mem_req is held by the master until mem_ack (or its own timeout).
// master = sequencer side, slave = register file / memory side.
interface store_exec_ctrl_if;
   import store_exec_ctrl_pkg::*;

   logic            rf_rd_en;
   logic [4:0]      rf_raddr1;
   logic [4:0]      rf_raddr2;
   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;

   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_be;
   logic            mem_ack;

   modport master (
      output rf_rd_en, rf_raddr1, rf_raddr2,
      input  rf_rdata1, rf_rdata2,
      output mem_req, mem_addr, mem_wdata, mem_be,
      input  mem_ack
   );

   modport slave (
      input  rf_rd_en, rf_raddr1, rf_raddr2,
      output rf_rdata1, rf_rdata2,
      input  mem_req, mem_addr, mem_wdata, mem_be,
      output mem_ack
   );

endinterface

// File: rtl/store_lane_gen.sv
// store_lane_gen: byte enables, lane-replicated write data and alignment check for SB/SH/SW.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3, offset (addr[1:0]), rs2_val in; be, wdata, misaligned out.
module store_lane_gen
   import store_exec_ctrl_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] rs2_val,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic            misaligned
);

   always_comb begin
      be         = 4'b0000;
      wdata      = rs2_val;
      misaligned = 1'b0;
      case (funct3)
         F3_SB: begin
            be    = 4'b0001 << offset;
            wdata = {4{rs2_val[7:0]}};
         end
         F3_SH: begin
            be         = 4'b0011 << offset;
            wdata      = {2{rs2_val[15:0]}};
            misaligned = offset[0];
         end
         F3_SW: begin
            be         = 4'b1111;
            misaligned = |offset;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_exec_ctrl.sv
// store_exec_ctrl: RISC-V S-type store sequencer (decode, RF read, address/lane generation, mem write).
// Latency: start at edge 0 -> DECODE 1, READ 2, EXEC 3, REQ from 4; done earliest in cycle 5.
// Backpressure: mem_req held until mem_ack or TIMEOUT cycles; start ignored while busy (no queueing).
// Ports: clk, rst (async, active high), start, instruction_word, busy, done, illegal_err,
//        misaligned_err, timeout_err; bus (master) carries the RF read and memory write ports.
module store_exec_ctrl
   import store_exec_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        instruction_word,
   output logic               busy,
   output logic               done,
   output logic               illegal_err,
   output logic               misaligned_err,
   output logic               timeout_err,
   store_exec_ctrl_if.master  bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state, state_nxt;
   err_t            err_q, err_nxt;
   logic [31:0]     instr_q;
   logic [TW-1:0]   to_cnt;
   logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
   logic [3:0]      mem_be_q;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [11:0]     imm;
   logic            legal;
   logic [XLEN-1:0] addr;
   logic [3:0]      lane_be;
   logic [XLEN-1:0] lane_wdata;
   logic            lane_mis;
   logic            last_count;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign imm    = {instr_q[31:25], instr_q[11:7]};
   assign legal  = (opcode == OPC_STORE) &&
                   ((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));

   // Only meaningful in EXEC, when rf_rdata1 carries the rs1 value.
   assign addr = bus.rf_rdata1 + sext12(imm);

   store_lane_gen u_lane_gen (
      .funct3     (funct3),
      .offset     (addr[1:0]),
      .rs2_val    (bus.rf_rdata2),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .misaligned (lane_mis)
   );

   // Counter holds the number of REQ cycles already spent without ack.
   assign last_count = (to_cnt == TW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      case (state)
         S_IDLE:   if (start) state_nxt = S_DECODE;
         S_DECODE: begin
            if (!legal) begin
               state_nxt = S_ERR;
               err_nxt   = ERR_ILLEGAL;
            end else begin
               state_nxt = S_READ;
            end
         end
         S_READ:   state_nxt = S_EXEC;
         S_EXEC: begin
            if (lane_mis) begin
               state_nxt = S_ERR;
               err_nxt   = ERR_MISALIGN;
            end else begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // Ack has priority over an expiring count.
            if (bus.mem_ack) begin
               state_nxt = S_DONE;
            end else if (last_count) begin
               state_nxt = S_ERR;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         S_DONE:   state_nxt = S_IDLE;
         S_ERR: begin
            state_nxt = S_IDLE;
            err_nxt   = ERR_NONE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         err_q       <= ERR_NONE;
         instr_q     <= '0;
         to_cnt      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (state == S_IDLE && start) instr_q <= instruction_word;
         if (state == S_REQ && !bus.mem_ack) to_cnt <= to_cnt + 1'b1;
         else                                to_cnt <= '0;
         if (state == S_EXEC && !lane_mis) begin
            mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
            mem_wdata_q <= lane_wdata;
            mem_be_q    <= lane_be;
         end
      end
   end

   // Decoded from the state register so an async reset clears them at once.
   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign illegal_err    = (state == S_ERR) && (err_q == ERR_ILLEGAL);
   assign misaligned_err = (state == S_ERR) && (err_q == ERR_MISALIGN);
   assign timeout_err    = (state == S_ERR) && (err_q == ERR_TIMEOUT);

   assign bus.rf_rd_en  = (state == S_READ);
   assign bus.rf_raddr1 = instr_q[19:15];
   assign bus.rf_raddr2 = instr_q[24:20];
   assign bus.mem_req   = (state == S_REQ);
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_exec_ctrl.sv
module tb_store_exec_ctrl;

   localparam int TO     = 16;
   localparam int BOUND  = TO + 10;
   localparam int K_DONE = 0;
   localparam int K_ILL  = 1;
   localparam int K_MIS  = 2;
   localparam int K_TMO  = 3;
   localparam logic [6:0] OPC = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] instruction_word = '0;
   logic        busy, done, illegal_err, misaligned_err, timeout_err;

   store_exec_ctrl_if bus();

   store_exec_ctrl #(.TIMEOUT(TO)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .instruction_word (instruction_word),
      .busy             (busy),
      .done             (done),
      .illegal_err      (illegal_err),
      .misaligned_err   (misaligned_err),
      .timeout_err      (timeout_err),
      .bus              (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] rf [32];
   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      int kind; int end_cyc; int req_cycles; logic rd;
      logic [31:0] maddr; logic [3:0] be; logic [31:0] wdata;
   } exp_t;

   typedef struct {
      int kind; int end_cyc; int pulses; int req_cycles; logic rd;
      logic [31:0] maddr; logic [3:0] be; logic [31:0] wdata;
      logic unstable; logic busy_bad; logic busy_after;
   } obs_t;

   typedef struct {
      logic [6:0] opc; logic [2:0] f3; logic [4:0] rs1; logic [4:0] rs2; logic [11:0] imm;
      logic [31:0] rs1_val; logic [31:0] rs2_val; int ack_at; int dup; exp_t e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
   endfunction

   // Reference: outcome of one store from the architectural rules, using plain arithmetic.
   function automatic exp_t model(input logic [31:0] instr, input int ack_at);
      exp_t e;
      logic [11:0] imm;
      int simm, size;
      logic [31:0] a, rs2v;
      e = '{kind:K_ILL, end_cyc:2, req_cycles:0, rd:1'b0, maddr:'0, be:'0, wdata:'0};
      if (instr[6:0] != OPC || instr[14:12] > 3'd2) return e;
      e.rd = 1'b1;
      imm  = {instr[31:25], instr[11:7]};
      simm = int'(imm);
      if (simm >= 2048) simm -= 4096;
      a    = rf[instr[19:15]] + 32'(simm);
      size = 1 << instr[14:12];
      if (a % size != 0) begin
         e.kind = K_MIS; e.end_cyc = 4;
         return e;
      end
      rs2v    = rf[instr[24:20]];
      e.maddr = a - (a % 4);
      e.be    = 4'(((1 << size) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2v[8*(i % size) +: 8];
      if (ack_at >= 1 && ack_at <= TO) begin
         e.kind = K_DONE; e.end_cyc = 4 + ack_at; e.req_cycles = ack_at;
      end else begin
         e.kind = K_TMO; e.end_cyc = 4 + TO; e.req_cycles = TO;
      end
      return e;
   endfunction

   // Drive one instruction and act as RF and memory until one cycle after the end pulse.
   task automatic run_txn(input logic [31:0] instr, input int ack_at, input int dup, output obs_t o);
      logic rd_prev;
      logic [4:0] a1, a2;
      o = '{kind:-1, end_cyc:-1, pulses:0, req_cycles:0, rd:1'b0, maddr:'0, be:'0,
            wdata:'0, unstable:1'b0, busy_bad:1'b0, busy_after:1'b1};
      rd_prev = 1'b0; a1 = '0; a2 = '0;
      @(negedge clk);
      start = 1'b1; instruction_word = instr; bus.mem_ack = 1'b0;
      for (int cyc = 1; cyc <= BOUND; cyc++) begin
         @(negedge clk);
         start = (cyc == dup);
         instruction_word = $urandom();
         bus.mem_ack = 1'b0;
         // Synchronous-read RF: data for an address is valid only in the following cycle.
         if (rd_prev) begin
            bus.rf_rdata1 = rf[a1]; bus.rf_rdata2 = rf[a2];
         end else begin
            bus.rf_rdata1 = $urandom(); bus.rf_rdata2 = $urandom();
         end
         rd_prev = bus.rf_rd_en;
         if (bus.rf_rd_en) begin
            o.rd = 1'b1; a1 = bus.rf_raddr1; a2 = bus.rf_raddr2;
         end
         if (bus.mem_req) begin
            o.req_cycles++;
            if (o.req_cycles == 1) begin
               o.maddr = bus.mem_addr; o.be = bus.mem_be; o.wdata = bus.mem_wdata;
            end else if (o.maddr !== bus.mem_addr || o.be !== bus.mem_be || o.wdata !== bus.mem_wdata) begin
               o.unstable = 1'b1;
            end
            if (o.req_cycles == ack_at) bus.mem_ack = 1'b1;
         end
         o.pulses += int'(done) + int'(illegal_err) + int'(misaligned_err) + int'(timeout_err);
         if (o.end_cyc < 0) begin
            if (done)           begin o.kind = K_DONE; o.end_cyc = cyc; end
            if (illegal_err)    begin o.kind = K_ILL;  o.end_cyc = cyc; end
            if (misaligned_err) begin o.kind = K_MIS;  o.end_cyc = cyc; end
            if (timeout_err)    begin o.kind = K_TMO;  o.end_cyc = cyc; end
         end
         if (o.end_cyc >= 0 && cyc == o.end_cyc + 1) begin
            o.busy_after = busy;
            break;
         end else if (!busy) begin
            o.busy_bad = 1'b1;
         end
      end
      start = 1'b0; bus.mem_ack = 1'b0;
   endtask

   task automatic compare(input string tag, input obs_t o, input exp_t e);
      chk({tag, " kind"}, o.kind, e.kind);
      chk({tag, " end_cycle"}, o.end_cyc, e.end_cyc);
      chk({tag, " pulse_count"}, o.pulses, 1);
      chk({tag, " rf_rd_seen"}, o.rd, e.rd);
      chk({tag, " req_cycles"}, o.req_cycles, e.req_cycles);
      if (e.req_cycles > 0) begin
         chk({tag, " mem_addr"}, o.maddr, e.maddr);
         chk({tag, " mem_be"}, o.be, e.be);
         chk({tag, " mem_wdata"}, o.wdata, e.wdata);
         chk({tag, " mem_stable"}, o.unstable, 1'b0);
      end
      chk({tag, " busy_gap"}, o.busy_bad, 1'b0);
      chk({tag, " busy_after"}, o.busy_after, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ctl"}, {busy, done, illegal_err, misaligned_err, timeout_err,
                          bus.rf_rd_en, bus.mem_req, bus.mem_be}, '0);
      chk({tag, " raddr"}, {bus.rf_raddr1, bus.rf_raddr2}, '0);
      chk({tag, " mem_addr"}, bus.mem_addr, '0);
      chk({tag, " mem_wdata"}, bus.mem_wdata, '0);
   endtask

   vec_t tbl [14];
   obs_t o;
   exp_t e;
   logic [31:0] ins;
   int w, pulses_seen, busy_seen, ack_at;

   initial begin
      bus.rf_rdata1 = '0; bus.rf_rdata2 = '0; bus.mem_ack = 1'b0;
      for (int j = 0; j < 32; j++) rf[j] = $urandom();

      //           opc            f3      rs1 rs2 imm      rs1_val        rs2_val        ack dup  {kind,end,req,rd,maddr,be,wdata}
      tbl[0]  = '{OPC,           3'b010,  2,  5, 12'h000, 32'h0000_1000, 32'hDEAD_BEEF, 1,  0, '{K_DONE, 5, 1, 1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF}};
      tbl[1]  = '{OPC,           3'b000,  1,  3, 12'hFFF, 32'h0000_2002, 32'h0000_00A5, 1,  0, '{K_DONE, 5, 1, 1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5}};
      tbl[2]  = '{OPC,           3'b001,  4,  6, 12'h001, 32'h0000_3000, 32'h0000_1234, 1,  0, '{K_MIS,  4, 0, 1, 32'h0, 4'b0, 32'h0}};
      tbl[3]  = '{OPC,           3'b011,  7,  8, 12'h000, 32'h0000_0000, 32'h0000_0000, 1,  0, '{K_ILL,  2, 0, 0, 32'h0, 4'b0, 32'h0}};
      tbl[4]  = '{7'b0110011,    3'b010,  7,  8, 12'h000, 32'h0000_0000, 32'h0000_0000, 1,  0, '{K_ILL,  2, 0, 0, 32'h0, 4'b0, 32'h0}};
      tbl[5]  = '{OPC,           3'b010,  9, 10, 12'h000, 32'h0000_0100, 32'hCAFE_F00D, 0,  0, '{K_TMO, 20, 16, 1, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D}};
      tbl[6]  = '{OPC,           3'b010,  9, 10, 12'h000, 32'h0000_0100, 32'hCAFE_F00D, 16, 0, '{K_DONE, 20, 16, 1, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D}};
      tbl[7]  = '{OPC,           3'b010,  1,  2, 12'h004, 32'hFFFF_FFFC, 32'h0BAD_C0DE, 1,  0, '{K_DONE, 5, 1, 1, 32'h0000_0000, 4'b1111, 32'h0BAD_C0DE}};
      tbl[8]  = '{OPC,           3'b001,  6, 11, 12'h002, 32'h0000_4000, 32'h1234_ABCD, 3,  0, '{K_DONE, 7, 3, 1, 32'h0000_4000, 4'b1100, 32'hABCD_ABCD}};
      tbl[9]  = '{OPC,           3'b000, 12, 13, 12'h003, 32'h0000_5000, 32'h0000_0077, 2,  0, '{K_DONE, 6, 2, 1, 32'h0000_5000, 4'b1000, 32'h7777_7777}};
      tbl[10] = '{OPC,           3'b010, 14, 15, 12'h000, 32'h0000_6002, 32'h0000_0000, 1,  0, '{K_MIS,  4, 0, 1, 32'h0, 4'b0, 32'h0}};
      tbl[11] = '{OPC,           3'b010,  2,  5, 12'h008, 32'h0000_1000, 32'h1122_3344, 2,  3, '{K_DONE, 6, 2, 1, 32'h0000_1008, 4'b1111, 32'h1122_3344}};
      tbl[12] = '{OPC,           3'b010,  2,  5, 12'h008, 32'h0000_1000, 32'h1122_3344, 2,  6, '{K_DONE, 6, 2, 1, 32'h0000_1008, 4'b1111, 32'h1122_3344}};
      tbl[13] = '{OPC,           3'b001,  3,  4, 12'hFFE, 32'h0000_0010, 32'hFFFF_8001, 1,  0, '{K_DONE, 5, 1, 1, 32'h0000_000C, 4'b1100, 32'h8001_8001}};

      // Power-on reset.
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         rf[tbl[i].rs1] = tbl[i].rs1_val;
         rf[tbl[i].rs2] = tbl[i].rs2_val;
         run_txn(enc(tbl[i].opc, tbl[i].f3, tbl[i].rs1, tbl[i].rs2, tbl[i].imm),
                 tbl[i].ack_at, tbl[i].dup, o);
         compare($sformatf("vec%0d", i), o, tbl[i].e);
      end

      // Reset while a request is outstanding.
      ins = enc(OPC, 3'b010, 2, 5, 12'h000);
      @(negedge clk);
      start = 1'b1; instruction_word = ins;
      bus.rf_rdata1 = 32'h0000_7000; bus.rf_rdata2 = 32'h5555_AAAA; bus.mem_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (w < 10 && !bus.mem_req) begin
         @(negedge clk);
         w++;
      end
      chk("rst_in_req reached_req", bus.mem_req, 1'b1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_zero("rst_in_req");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      pulses_seen = 0; busy_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         pulses_seen += int'(done) + int'(illegal_err) + int'(misaligned_err) + int'(timeout_err);
         busy_seen += int'(busy) + int'(bus.mem_req);
      end
      chk("rst_in_req no_pulse", pulses_seen, 0);
      chk("rst_in_req idle", busy_seen, 0);

      // After reset the timeout count starts from zero: ack on the last count still completes.
      rf[9] = 32'h0000_0200; rf[10] = 32'h0F0F_0F0F;
      ins = enc(OPC, 3'b010, 9, 10, 12'h000);
      e = model(ins, TO);
      run_txn(ins, TO, 0, o);
      compare("post_rst", o, e);

      // Randomized stores against the reference model.
      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < 32; j++) rf[j] = $urandom();
         if ($urandom_range(0, 1) == 1) for (int j = 0; j < 32; j++) rf[j][1:0] = 2'b00;
         ins = enc(OPC, 3'($urandom_range(0, 2)), 5'($urandom()), 5'($urandom()), 12'($urandom()));
         if ($urandom_range(0, 1) == 1) ins[8:7] = 2'b00;
         case ($urandom_range(0, 9))
            0: ins[6:0] = 7'b0110011;
            1: ins[14:12] = 3'($urandom_range(3, 7));
            default: ;
         endcase
         ack_at = $urandom_range(0, TO + 1);
         e = model(ins, ack_at);
         run_txn(ins, ack_at, (k % 5 == 0) ? 2 : 0, o);
         compare($sformatf("rnd%0d", k), o, e);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
